edge_result_writer: RTL and testbench
=====================================

Name: edge_result_writer

Overview:
- Downstream stage of the Sobel edge detector.
- Accepts packed 32-bit edge-result words (4 pixels, byte 0 = leftmost) over a valid/ready stream.
- Buffers them in a small FIFO and writes them to the framestore through the drawing-engine req/ack bus at raster-order word addresses.
- Reports busy and done to the top-level controller.

Parameters:
- FIFO_DEPTH, 4, result-word FIFO entries; power of 2, at least 2.
- WORDS_PER_LINE, 160, 32-bit words per output line (640 px / 4).
- LINES, 480, output lines per frame.
- BASE_ADDR, 18'h00000, framestore word address of the first output word.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins a frame when idle.
- busy  out  1  high from the cycle after start is accepted until done is asserted.
- done  out  1  one-cycle pulse after the last frame word is acknowledged.
- in_valid  in  1  result word available.
- in_data  in  32  packed edge result word.
- in_ready  out  1  writer accepts in_data this cycle.
- de_req  out  1  framestore write request.
- de_ack  in  1  framestore accepted the current request.
- de_addr  out  18  framestore word address.
- de_nbyte  out  4  byte-write enables, active high.
- de_rnw  out  1  read-not-write; always 0 from this block.
- de_w_data  out  32  write data.

Behaviour:
- Reset, asynchronous on rst_n low:
  - All outputs 0: de_addr 0, de_w_data 0, de_nbyte 4'b0000.
  - FIFO emptied, counters cleared, state IDLE.
  - A reset mid-frame drops de_req immediately; no write completes.
- State machine:
  - IDLE: start=1 clears the accept counter and write counter, then goes to RUN. busy rises next cycle.
  - RUN: accepts and writes concurrently. When accept count reaches TOTAL = WORDS_PER_LINE*LINES, go to DRAIN.
  - DRAIN: in_ready=0. When the FIFO is empty and the last write is acknowledged, go to DONE.
  - DONE: done=1 and busy=0 for one cycle, then IDLE.
- start while not in IDLE is ignored.
- Input stream:
  - in_ready = (state==RUN) and registered FIFO count < FIFO_DEPTH and accept count < TOTAL.
  - A word is accepted when in_valid and in_ready are both high.
  - in_ready does not depend combinationally on a same-cycle pop, so a full FIFO refuses input even while a pop occurs.
- Framestore handshake:
  - de_req rises the cycle after the FIFO becomes non-empty.
  - de_addr, de_w_data and de_nbyte are registered from the FIFO head and held stable while de_req=1 and de_ack=0.
  - de_nbyte = 4'b1111 whenever de_req=1.
  - On a cycle with de_req=1 and de_ack=1: pop the FIFO and increment the write counter. If another entry is present after the pop, de_req stays high and the next word and address are presented the following cycle (back-to-back). Otherwise de_req falls.
  - de_ack while de_req=0 is ignored.
- Addressing:
  - de_addr = BASE_ADDR + write counter, 18-bit with wrap.
  - The write counter is 18 bits and counts 0..TOTAL-1; the default TOTAL of 76800 fits.
  - There is no per-line gap. Line breaks are implicit in the count.
- Latency: an accepted word reaches de_req at the earliest 2 cycles after acceptance when the FIFO was empty.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- Pointer wrap: pointers are modulo FIFO_DEPTH; the count register disambiguates full from empty.

Decomposition:
- Shared package edge_pkg holds:
  - state encodings EW_IDLE, EW_RUN, EW_DRAIN, EW_DONE;
  - DE_ADDR_W = 18 and DE_DATA_W = 32;
  - DE_NBYTE_ALL = 4'b1111.
- One sub-module: edge_word_fifo (parameterised depth, 32-bit, push/pop/count/full/empty, async active-low reset).
- Sequencing and address generation stay in edge_result_writer.

Test Plan:
- All scenarios use WORDS_PER_LINE=4, LINES=2 (TOTAL=8), BASE_ADDR=18'h00100 unless noted.
- Basic flow: pulse start, stream 8 words 32'h01010101..32'h08080808 with de_ack tied to 1. Writes appear at de_addr 0x100..0x107 in order with matching data. done pulses once, then busy=0.
- Backpressure: de_ack held 0 for 20 cycles after the first request. Exactly 4 words are accepted, in_ready=0 thereafter, and de_req/de_addr/de_w_data stay stable. After de_ack=1, all 8 words complete in order.
- Back-to-back: FIFO preloaded with 3 words and de_ack=1 continuously. de_req stays high for 3 consecutive cycles with addresses incrementing by 1 each cycle.
- Start ignored: a second start pulse mid-frame (after 3 words) does not reset the counters. Writes continue at 0x103 and done pulses once.
- Reset mid-frame: rst_n low during an outstanding de_req. de_req, busy and in_ready drop asynchronously. After release and a new start, the first write is at 0x100.
- Wrap: BASE_ADDR=18'h3FFFE. Writes go to 0x3FFFE, 0x3FFFF, 0x00000 ... 0x00005.

Source files
------------

// File: rtl/edge_pkg.sv
`timescale 1ns/1ps
// edge_pkg: shared constants for the Sobel edge-result writer.
// Latency: n/a (definitions only).
// Backpressure: n/a.
// Holds the writer FSM state encodings and the drawing-engine bus widths.
package edge_pkg;

  localparam int DE_ADDR_W = 18;
  localparam int DE_DATA_W = 32;

  localparam logic [3:0] DE_NBYTE_ALL = 4'b1111;

  // Writer sequencing states.
  localparam logic [1:0] EW_IDLE  = 2'd0;
  localparam logic [1:0] EW_RUN   = 2'd1;
  localparam logic [1:0] EW_DRAIN = 2'd2;
  localparam logic [1:0] EW_DONE  = 2'd3;

endpackage

// File: rtl/edge_word_fifo.sv
`timescale 1ns/1ps
// edge_word_fifo: small power-of-2 depth word FIFO for edge results.
// Latency: a pushed word is visible at o_head the cycle after the push.
// Backpressure: caller must not push when o_full nor pop when o_empty (both are ignored).
// Ports: clk, rst_n (async active-low); i_push/i_data write side; i_pop read side;
//        o_head = oldest entry, o_next = entry behind it; o_count/o_full/o_empty status.
module edge_word_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_data,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_head,
  output logic [WIDTH-1:0]           o_next,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_full,
  output logic                       o_empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic w_push;
  logic w_pop;

  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;

  assign w_push = i_push && !o_full;
  assign w_pop  = i_pop && !o_empty;

  assign o_head = r_mem[r_rd_ptr];
  // Second read port lets the consumer present the following word back-to-back
  // in the same cycle the head is retired.
  assign o_next = r_mem[r_rd_ptr + PTR_W'(1)];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Pointers wrap naturally since DEPTH is a power of 2; the count register
  // separates full from empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/edge_result_writer.sv
`timescale 1ns/1ps
// edge_result_writer: buffers packed 4-pixel edge words and writes them to the framestore in raster order.
// Latency: an accepted word raises de_req 2 cycles later when the FIFO was empty; back-to-back writes on continuous ack.
// Backpressure: in_ready drops when the FIFO is full (registered count) or the frame is fully accepted; de_req holds until de_ack.
// Ports: clk, rst_n (async active-low); start/busy/done controller handshake;
//        in_valid/in_data/in_ready result stream; de_req/de_ack/de_addr/de_nbyte/de_rnw/de_w_data framestore bus.
module edge_result_writer
  import edge_pkg::*;
#(
  parameter int                   FIFO_DEPTH     = 4,
  parameter int                   WORDS_PER_LINE = 160,
  parameter int                   LINES          = 480,
  parameter logic [DE_ADDR_W-1:0] BASE_ADDR      = 18'h00000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  input  logic                 in_valid,
  input  logic [DE_DATA_W-1:0] in_data,
  output logic                 in_ready,
  output logic                 de_req,
  input  logic                 de_ack,
  output logic [DE_ADDR_W-1:0] de_addr,
  output logic [3:0]           de_nbyte,
  output logic                 de_rnw,
  output logic [DE_DATA_W-1:0] de_w_data
);

  localparam int                   CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [DE_ADDR_W-1:0] TOTAL = DE_ADDR_W'(WORDS_PER_LINE * LINES);
  localparam logic [DE_ADDR_W-1:0] LAST  = TOTAL - DE_ADDR_W'(1);

  logic [1:0]           r_state;
  logic [DE_ADDR_W-1:0] r_acc_cnt;
  logic [DE_ADDR_W-1:0] r_wr_cnt;
  logic                 r_req;
  logic [DE_ADDR_W-1:0] r_addr;
  logic [DE_DATA_W-1:0] r_data;

  logic [DE_DATA_W-1:0] w_head;
  logic [DE_DATA_W-1:0] w_next;
  logic [CNT_W-1:0]     w_fifo_count;
  logic                 w_fifo_full;
  logic                 w_fifo_empty;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_deep;
  logic                 w_more;
  logic [DE_DATA_W-1:0] w_next_word;

  assign in_ready = (r_state == EW_RUN) && !w_fifo_full && (r_acc_cnt < TOTAL);
  assign w_push   = in_valid && in_ready;
  assign w_pop    = r_req && de_ack;

  // After retiring the head, another word is available either from the FIFO
  // (more than one entry held) or from a push landing this very cycle when
  // the head was the only entry.
  assign w_deep      = (w_fifo_count > CNT_W'(1));
  assign w_more      = w_deep || w_push;
  assign w_next_word = w_deep ? w_next : in_data;

  edge_word_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DE_DATA_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_data  (in_data),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_next  (w_next),
    .o_count (w_fifo_count),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  // Frame sequencing and counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= EW_IDLE;
      r_acc_cnt <= '0;
      r_wr_cnt  <= '0;
    end else begin
      if (r_state == EW_IDLE && start) begin
        r_wr_cnt <= '0;
      end else if (w_pop) begin
        r_wr_cnt <= r_wr_cnt + DE_ADDR_W'(1);
      end

      case (r_state)
        EW_IDLE: begin
          if (start) begin
            r_acc_cnt <= '0;
            r_state   <= EW_RUN;
          end
        end
        EW_RUN: begin
          if (w_push) begin
            r_acc_cnt <= r_acc_cnt + DE_ADDR_W'(1);
            if (r_acc_cnt == LAST) r_state <= EW_DRAIN;
          end
        end
        EW_DRAIN: begin
          // Empty FIFO with no request outstanding means the last write was acked.
          if (w_fifo_empty && !r_req) r_state <= EW_DONE;
        end
        default: begin
          r_state <= EW_IDLE;
        end
      endcase
    end
  end

  // Framestore request register: loaded from the FIFO head, held until acked.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_req  <= 1'b0;
      r_addr <= '0;
      r_data <= '0;
    end else if (w_pop) begin
      if (w_more) begin
        r_req  <= 1'b1;
        r_addr <= BASE_ADDR + r_wr_cnt + DE_ADDR_W'(1);
        r_data <= w_next_word;
      end else begin
        r_req  <= 1'b0;
      end
    end else if (!r_req && !w_fifo_empty) begin
      r_req  <= 1'b1;
      r_addr <= BASE_ADDR + r_wr_cnt;
      r_data <= w_head;
    end
  end

  assign de_req    = r_req;
  assign de_addr   = r_addr;
  assign de_w_data = r_data;
  assign de_nbyte  = r_req ? DE_NBYTE_ALL : 4'b0000;
  assign de_rnw    = 1'b0;

  assign busy = (r_state == EW_RUN) || (r_state == EW_DRAIN);
  assign done = (r_state == EW_DONE);

endmodule

// File: tb/tb_edge_result_writer.sv
`timescale 1ns/1ps
module tb_edge_result_writer;

  localparam int TOT = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        de_ack = 1'b0;

  logic        busy, done, in_ready, de_req, de_rnw;
  logic [17:0] de_addr;
  logic [3:0]  de_nbyte;
  logic [31:0] de_w_data;

  logic        busy_w, done_w, in_ready_w, de_req_w, de_rnw_w;
  logic [17:0] de_addr_w;
  logic [3:0]  de_nbyte_w;
  logic [31:0] de_w_data_w;

  edge_result_writer #(
    .FIFO_DEPTH(4), .WORDS_PER_LINE(4), .LINES(2), .BASE_ADDR(18'h00100)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .de_req(de_req), .de_ack(de_ack), .de_addr(de_addr), .de_nbyte(de_nbyte),
    .de_rnw(de_rnw), .de_w_data(de_w_data)
  );

  // Identical stimulus, base address near the top of the 18-bit space.
  edge_result_writer #(
    .FIFO_DEPTH(4), .WORDS_PER_LINE(4), .LINES(2), .BASE_ADDR(18'h3FFFE)
  ) dut_w (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy_w), .done(done_w),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready_w),
    .de_req(de_req_w), .de_ack(de_ack), .de_addr(de_addr_w), .de_nbyte(de_nbyte_w),
    .de_rnw(de_rnw_w), .de_w_data(de_w_data_w)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    int          idx;
  } exp_t;

  exp_t q[$];
  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  int sent_k   = 0;
  int acc_idx  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] word_of(input int i);
    logic [7:0] b;
    b = 8'(i + 1);
    return {b, b, b, b};
  endfunction

  // Scoreboard: every accepted write must match the oldest expected entry.
  always begin
    @(negedge clk);
    #1;
    if (rst_n && de_req && de_ack) begin
      chk("write_expected", 32'(q.size() != 0), 32'd1);
      if (q.size() != 0) begin
        exp_t e;
        logic [17:0] ea, ew;
        e  = q.pop_front();
        ea = 18'(18'h00100 + e.idx);
        ew = 18'(18'h3FFFE + e.idx);
        chk("wr_addr", 32'(de_addr), 32'(ea));
        chk("wr_data", de_w_data, e.data);
        chk("wr_nbyte", 32'(de_nbyte), 32'hF);
        chk("wr_rnw", 32'(de_rnw), 32'd0);
        chk("wrap_addr", 32'(de_addr_w), 32'(ew));
        chk("wrap_data", de_w_data_w, e.data);
      end
    end
  end

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Present words sent_k..limit-1, pushing expectations as each is accepted.
  task automatic stream(input int limit, input int cycles);
    for (int c = 0; c < cycles && sent_k < limit; c++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = word_of(sent_k);
      if (in_ready) begin
        q.push_back('{word_of(sent_k), acc_idx});
        acc_idx++;
        sent_k++;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int pulses = 0;
    int post   = 0;
    for (int c = 0; c < 200 && post < 4; c++) begin
      @(negedge clk);
      #1;
      if (done) begin
        pulses++;
        chk({tag, "_busy_at_done"}, 32'(busy), 32'd0);
      end
      if (pulses > 0 && !done) post++;
    end
    chk({tag, "_done_pulses"}, pulses, 1);
    chk({tag, "_busy_after"}, 32'(busy), 32'd0);
    chk({tag, "_queue_empty"}, q.size(), 0);
    chk({tag, "_words_sent"}, sent_k, TOT);
  endtask

  task automatic new_frame();
    sent_k  = 0;
    acc_idx = 0;
    q.delete();
  endtask

  initial begin
    // Reset state.
    #2;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_de_req", 32'(de_req), 32'd0);
    chk("rst_de_addr", 32'(de_addr), 32'd0);
    chk("rst_de_w_data", de_w_data, 32'd0);
    chk("rst_de_nbyte", 32'(de_nbyte), 32'd0);
    chk("rst_wrap_addr", 32'(de_addr_w), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    chk("idle_in_ready", 32'(in_ready), 32'd0);

    // Basic flow with ack tied high.
    new_frame();
    de_ack = 1'b1;
    pulse_start();
    #1;
    chk("basic_busy", 32'(busy), 32'd1);
    stream(TOT, 60);
    wait_done("basic");

    // Backpressure: ack low, FIFO fills to exactly its depth.
    new_frame();
    de_ack = 1'b0;
    pulse_start();
    stream(TOT, 20);
    #1;
    chk("bp_accepted", sent_k, 4);
    chk("bp_in_ready", 32'(in_ready), 32'd0);
    chk("bp_de_req", 32'(de_req), 32'd1);
    chk("bp_de_addr", 32'(de_addr), 32'h100);
    chk("bp_de_w_data", de_w_data, 32'h01010101);
    repeat (3) @(negedge clk);
    #1;
    chk("bp_hold_addr", 32'(de_addr), 32'h100);
    chk("bp_hold_data", de_w_data, 32'h01010101);
    chk("bp_hold_req", 32'(de_req), 32'd1);
    @(negedge clk);
    de_ack = 1'b1;
    stream(TOT, 60);
    wait_done("bp");

    // Back-to-back: 3 words queued, then continuous ack.
    new_frame();
    de_ack = 1'b0;
    pulse_start();
    stream(3, 10);
    repeat (2) @(negedge clk);
    @(negedge clk);
    de_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("b2b_req", 32'(de_req), 32'd1);
      chk("b2b_addr", 32'(de_addr), 32'(18'h100 + 18'(i)));
      @(negedge clk);
    end
    #1;
    chk("b2b_req_fall", 32'(de_req), 32'd0);
    stream(TOT, 60);
    wait_done("b2b");

    // Second start mid-frame is ignored.
    new_frame();
    de_ack = 1'b1;
    pulse_start();
    stream(3, 20);
    pulse_start();
    #1;
    chk("ign_busy", 32'(busy), 32'd1);
    stream(TOT, 60);
    wait_done("ign");

    // Reset while a request is outstanding.
    new_frame();
    de_ack = 1'b0;
    pulse_start();
    stream(1, 10);
    for (int c = 0; c < 10 && !de_req; c++) @(negedge clk);
    chk("mid_req_up", 32'(de_req), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_req", 32'(de_req), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
    chk("mid_rst_addr", 32'(de_addr), 32'd0);
    new_frame();
    @(negedge clk);
    rst_n = 1'b1;
    de_ack = 1'b1;
    pulse_start();
    stream(TOT, 60);
    wait_done("post_rst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
